alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/cpu_types_pkg.sv | 30 +++
 rtl/alu_arbiter_if.sv | 29 ++
 rtl/alu_if.sv | 15 +
 rtl/alu.sv | 38 +++
 rtl/alu_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_arbiter.sv | 292 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU operation/word types and the arbiter FSM encoding.
package cpu_types_pkg;

  localparam int unsigned ARB_REQS = 2;
  localparam int unsigned WORD_W   = 32;

  typedef logic [WORD_W-1:0] word_t;

  // 4-bit encoding leaves 7..15 unsupported; the ALU returns all-zero for those.
  typedef enum logic [3:0] {
    ALU_SLL = 4'd0,
    ALU_SRL = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd3,
    ALU_AND = 4'd4,
    ALU_OR  = 4'd5,
    ALU_XOR = 4'd6
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic logic [ARB_REQS-1:0] onehot(logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-requester operation/result bus of alu_arbiter.
interface alu_arbiter_if;
  import cpu_types_pkg::*;

  logic [ARB_REQS-1:0] req;
  logic [ARB_REQS-1:0] gnt;
  logic [ARB_REQS-1:0] rvalid;
  logic [ARB_REQS-1:0] rready;
  aluop_t              op0;
  aluop_t              op1;
  word_t               a0;
  word_t               b0;
  word_t               a1;
  word_t               b1;
  word_t               rdata;
  logic                rneg;
  logic                rovf;
  logic                rzero;
  logic                busy;

  modport master (
    output req, op0, op1, a0, b0, a1, b1, rready,
    input  gnt, rvalid, rdata, rneg, rovf, rzero, busy
  );
  modport slave (
    input  req, op0, op1, a0, b0, a1, b1, rready,
    output gnt, rvalid, rdata, rneg, rovf, rzero, busy
  );
endinterface

// File: rtl/alu_if.sv
// Connection bundle between a user and the combinational alu block.
interface alu_if;
  import cpu_types_pkg::*;

  aluop_t op;
  word_t  port_a;
  word_t  port_b;
  word_t  OutputPort;
  logic   negative;
  logic   overflow;
  logic   zero;

  modport alu  (input op, port_a, port_b, output OutputPort, negative, overflow, zero);
  modport user (output op, port_a, port_b, input OutputPort, negative, overflow, zero);
endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU with Negative/Overflow/Zero flags.
module alu
  import cpu_types_pkg::*;
(
  alu_if.alu aif
);

  word_t res;
  logic  ovf;
  logic  known;

  always_comb begin
    res   = '0;
    ovf   = 1'b0;
    known = 1'b1;
    case (aif.op)
      ALU_SLL: res = aif.port_a << aif.port_b[4:0];
      ALU_SRL: res = aif.port_a >> aif.port_b[4:0];
      ALU_ADD: begin
        res = aif.port_a + aif.port_b;
        ovf = (aif.port_a[31] == aif.port_b[31]) && (res[31] != aif.port_a[31]);
      end
      ALU_SUB: begin
        res = aif.port_a - aif.port_b;
        ovf = (aif.port_a[31] != aif.port_b[31]) && (res[31] != aif.port_a[31]);
      end
      ALU_AND: res = aif.port_a & aif.port_b;
      ALU_OR:  res = aif.port_a | aif.port_b;
      ALU_XOR: res = aif.port_a ^ aif.port_b;
      default: known = 1'b0;
    endcase
    aif.OutputPort = res;
    aif.negative   = known & res[31];
    aif.overflow   = ovf;
    aif.zero       = known & (res == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU: IDLE -> EXEC -> RESP with registered result.
// Define ALU_ARBITER_RR_EN for round-robin contention; otherwise requester 0 always wins.
module alu_arbiter
  import cpu_types_pkg::*;
(
  input logic          CLK,
  input logic          nRST,
  alu_arbiter_if.slave bus
);

  arb_state_t          state_q, state_d;
  logic                owner_q, owner_d;
  aluop_t              op_q, op_d;
  word_t               a_q, a_d, b_q, b_d;
  word_t               rdata_q, rdata_d;
  logic                rneg_q, rneg_d, rovf_q, rovf_d, rzero_q, rzero_d;
  logic                winner;
  logic                can_grant;
  logic                grant;
  logic [ARB_REQS-1:0] gnt;

  alu_if alu_bus ();

  alu u_alu (
    .aif (alu_bus)
  );

  assign alu_bus.op     = op_q;
  assign alu_bus.port_a = a_q;
  assign alu_bus.port_b = b_q;

`ifdef ALU_ARBITER_RR_EN
  logic last_q, last_d;

  always_comb begin
    case (bus.req)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_q;
      default: winner = 1'b0;
    endcase
  end

  assign last_d = grant ? winner : last_q;

  // Pointer resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign winner = bus.req[1] & ~bus.req[0];
`endif

  // A new op is accepted from IDLE, or from RESP in the cycle the owner takes its result.
  assign can_grant = nRST && ((state_q == IDLE) ||
                              ((state_q == RESP) && bus.rready[owner_q]));
  assign grant     = can_grant && (bus.req != '0);
  assign gnt       = grant ? onehot(winner) : '0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rdata_d = rdata_q;
    rneg_d  = rneg_q;
    rovf_d  = rovf_q;
    rzero_d = rzero_q;
    case (state_q)
      IDLE: begin
        if (grant) state_d = EXEC;
      end
      EXEC: begin
        state_d = RESP;
        rdata_d = alu_bus.OutputPort;
        rneg_d  = alu_bus.negative;
        rovf_d  = alu_bus.overflow;
        rzero_d = alu_bus.zero;
      end
      RESP: begin
        if (bus.rready[owner_q]) state_d = grant ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      owner_d = winner;
      op_d    = winner ? bus.op1 : bus.op0;
      a_d     = winner ? bus.a1  : bus.a0;
      b_d     = winner ? bus.b1  : bus.b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      op_q    <= aluop_t'('0);
      a_q     <= '0;
      b_q     <= '0;
      rdata_q <= '0;
      rneg_q  <= 1'b0;
      rovf_q  <= 1'b0;
      rzero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rdata_q <= rdata_d;
      rneg_q  <= rneg_d;
      rovf_q  <= rovf_d;
      rzero_q <= rzero_d;
    end
  end

  assign bus.gnt    = gnt;
  assign bus.rvalid = (state_q == RESP) ? onehot(owner_q) : '0;
  assign bus.busy   = (state_q != IDLE);
  assign bus.rdata  = rdata_q;
  assign bus.rneg   = rneg_q;
  assign bus.rovf   = rovf_q;
  assign bus.rzero  = rzero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vectors, corner sequences, random traffic.
module tb_alu_arbiter;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic  neg;
    logic  ovf;
    logic  zero;
    word_t data;
  } res_t;

  typedef struct {
    bit     id;
    aluop_t op;
    word_t  a;
    word_t  b;
    res_t   exp;
  } vec_t;

  localparam longint MaxS = 64'sd2147483647;
  localparam longint MinS = -64'sd2147483648;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  // Reference model: one outstanding transaction with the cycle its result appears.
  bit          m_busy  = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_last  = 1'b1;
  int unsigned m_avail = 0;
  res_t        m_res   = '0;

  logic [1:0] obs_gnt, obs_rvalid;
  logic       obs_busy;
  res_t       obs_res;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic res_t ref_alu(aluop_t op, word_t a, word_t b);
    res_t   r;
    longint sa, sb, s;
    bit     known;
    r     = '0;
    known = 1'b1;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    case (op)
      ALU_ADD: begin s = sa + sb; r.data = a + b; r.ovf = (s > MaxS) || (s < MinS); end
      ALU_SUB: begin s = sa - sb; r.data = a - b; r.ovf = (s > MaxS) || (s < MinS); end
      ALU_AND: r.data = a & b;
      ALU_OR:  r.data = a | b;
      ALU_XOR: r.data = a ^ b;
      ALU_SLL: r.data = a << b[4:0];
      ALU_SRL: r.data = a >> b[4:0];
      default: known = 1'b0;
    endcase
    if (known) begin
      r.neg  = r.data[31];
      r.zero = (r.data == 0);
    end
    return r;
  endfunction

  function automatic bit pick(logic [1:0] req, bit last);
    if (req == 2'b01) return 1'b0;
    if (req == 2'b10) return 1'b1;
`ifdef ALU_ARBITER_RR_EN
    return !last;
`else
    return 1'b0;
`endif
  endfunction

  function automatic vec_t mk(bit id, aluop_t op, word_t a, word_t b,
                              logic n, logic o, logic z, word_t d);
    vec_t v;
    v.id = id; v.op = op; v.a = a; v.b = b;
    v.exp = {n, o, z, d};
    return v;
  endfunction

  function automatic word_t rnd_word();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_req(int i, aluop_t op, word_t a, word_t b);
    if (i == 0) begin
      bus.op0 = op; bus.a0 = a; bus.b0 = b; bus.req[0] = 1'b1;
    end else begin
      bus.op1 = op; bus.a1 = a; bus.b1 = b; bus.req[1] = 1'b1;
    end
  endtask

  // One clock: compare outputs against the model mid-cycle, advance the model, withdraw granted reqs.
  task automatic tick();
    logic [1:0] eg, ev;
    bit         acc, w;
    w = 1'b0;
    @(negedge clk);
    ev  = (m_busy && cyc >= m_avail) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    acc = !m_busy || (ev != 2'b00 && bus.rready[m_owner]);
    eg  = 2'b00;
    if (acc && bus.req != 2'b00) begin
      w  = pick(bus.req, m_last);
      eg = w ? 2'b10 : 2'b01;
    end
    obs_gnt    = bus.gnt;
    obs_rvalid = bus.rvalid;
    obs_busy   = bus.busy;
    obs_res    = {bus.rneg, bus.rovf, bus.rzero, bus.rdata};
    check("gnt", obs_gnt, eg);
    check("rvalid", obs_rvalid, ev);
    check("busy", obs_busy, m_busy);
    if (ev != 2'b00) check("result", obs_res, m_res);
    if (ev != 2'b00 && bus.rready[m_owner]) m_busy = 1'b0;
    if (eg != 2'b00) begin
      m_busy  = 1'b1;
      m_owner = w;
      m_last  = w;
      m_avail = cyc + 2;
      m_res   = w ? ref_alu(bus.op1, bus.a1, bus.b1) : ref_alu(bus.op0, bus.a0, bus.b0);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (eg[0]) bus.req[0] = 1'b0;
    if (eg[1]) bus.req[1] = 1'b0;
  endtask

  // Async reset with requests asserted: every output must be forced low.
  task automatic do_reset();
    rst_n      = 1'b0;
    bus.req    = 2'b11;
    bus.rready = 2'b00;
    #2;
    check("reset_outputs",
          {bus.gnt, bus.rvalid, bus.busy, bus.rneg, bus.rovf, bus.rzero, bus.rdata}, 64'd0);
    bus.req = 2'b00;
    m_busy  = 1'b0;
    m_last  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc += 2;
    rst_n = 1'b1;
  endtask

  vec_t vecs[12];
  logic [1:0] seen[$];
  logic [1:0] exp_order[4];
  res_t bp_exp;
  bit   rv_seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(0, ALU_ADD, 32'd5,         32'd7,         0, 0, 0, 32'd12);
    vecs[1]  = mk(1, ALU_ADD, 32'h7FFF_FFFF, 32'd1,         1, 1, 0, 32'h8000_0000);
    vecs[2]  = mk(0, ALU_SUB, 32'd9,         32'd4,         0, 0, 0, 32'd5);
    vecs[3]  = mk(1, ALU_SUB, 32'd4,         32'd4,         0, 0, 1, 32'd0);
    vecs[4]  = mk(0, ALU_SUB, 32'h8000_0000, 32'd1,         0, 1, 0, 32'h7FFF_FFFF);
    vecs[5]  = mk(1, ALU_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 0, 0, 32'h00F0_000F);
    vecs[6]  = mk(0, ALU_OR,  32'hF000_0000, 32'd1,         1, 0, 0, 32'hF000_0001);
    vecs[7]  = mk(1, ALU_XOR, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 32'd0);
    vecs[8]  = mk(0, ALU_SLL, 32'd1,         32'd31,        1, 0, 0, 32'h8000_0000);
    vecs[9]  = mk(1, ALU_ADD, 32'hFFFF_FFFF, 32'd1,         0, 0, 1, 32'd0);
    vecs[10] = mk(0, aluop_t'(4'hF), 32'd5,  32'd7,         0, 0, 0, 32'd0);
    vecs[11] = mk(1, ALU_SRL, 32'h8000_0000, 32'd4,         0, 0, 0, 32'h0800_0000);

    bus.req = 2'b00; bus.rready = 2'b00;
    bus.op0 = ALU_SLL; bus.op1 = ALU_SLL;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    #2;
    do_reset();

    // Directed single-request vectors: gnt at T, rvalid at T+2.
    foreach (vecs[k]) begin
      set_req(int'(vecs[k].id), vecs[k].op, vecs[k].a, vecs[k].b);
      bus.rready = 2'b11;
      tick();
      check($sformatf("vec%0d_gnt", k), obs_gnt, vecs[k].id ? 2'b10 : 2'b01);
      tick();
      check($sformatf("vec%0d_exec_rvalid", k), obs_rvalid, 2'b00);
      tick();
      check($sformatf("vec%0d_rvalid", k), obs_rvalid, vecs[k].id ? 2'b10 : 2'b01);
      check($sformatf("vec%0d_result", k), obs_res, vecs[k].exp);
    end

    // Reset during EXEC of SUB 9-4 aborts the transaction.
    set_req(0, ALU_SUB, 32'd9, 32'd4);
    bus.rready = 2'b11;
    tick();
    check("midreset_gnt", obs_gnt, 2'b01);
    do_reset();
    rv_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (obs_rvalid != 2'b00) rv_seen = 1'b1;
    end
    check("midreset_no_rvalid", rv_seen, 1'b0);

    // Contention straight after reset.
`ifdef ALU_ARBITER_RR_EN
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    set_req(0, ALU_ADD, $urandom, $urandom);
    set_req(1, ALU_SUB, $urandom, $urandom);
    bus.rready = 2'b11;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (obs_gnt != 2'b00) seen.push_back(obs_gnt);
      if (!bus.req[0]) set_req(0, ALU_XOR, $urandom, $urandom);
      if (!bus.req[1]) set_req(1, ALU_OR, $urandom, $urandom);
    end
    check("contention_count", seen.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < seen.size()) check($sformatf("contention_order%0d", k), seen[k], exp_order[k]);
    end
    bus.req = 2'b00;
    tick();
    tick();

    // Backpressure in RESP, then back-to-back hand-over to requester 1.
    set_req(0, ALU_ADD, 32'h1234_5678, 32'h0101_0101);
    bp_exp = ref_alu(ALU_ADD, 32'h1234_5678, 32'h0101_0101);
    bus.rready = 2'b00;
    tick();
    tick();
    set_req(1, ALU_SUB, 32'd100, 32'd1);
    for (int i = 0; i < 6; i++) begin
      bus.rready = (i == 3) ? 2'b10 : 2'b00;
      tick();
      check($sformatf("bp%0d_rvalid", i), obs_rvalid, 2'b01);
      check($sformatf("bp%0d_gnt", i), obs_gnt, 2'b00);
      check($sformatf("bp%0d_stable", i), obs_res, bp_exp);
    end
    bus.rready = 2'b01;
    tick();
    check("b2b_gnt", obs_gnt, 2'b10);
    tick();
    check("b2b_exec", {obs_busy, obs_rvalid}, 3'b100);
    bus.rready = 2'b11;
    tick();
    check("b2b_rvalid", obs_rvalid, 2'b10);
    check("b2b_result", obs_res, 35'({3'b000, 32'd99}));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!bus.req[r] && $urandom_range(0, 2) == 0) begin
          set_req(r, aluop_t'(4'($urandom_range(0, 8))), rnd_word(), rnd_word());
        end
      end
      bus.rready = 2'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
